// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// Build option WB_BYPASS_EN (see wb_arbiter) does not affect anything in this package.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int REG_NUM   = 2 ** WB_ADDR_W;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [REG_NUM-1:0] onehot_addr(input logic [WB_ADDR_W-1:0] a);
    logic [REG_NUM-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for slow-unit results waiting for a free write-port cycle.
// Exposes every slot plus a per-slot valid bit so the owner can build a pending mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  wb_req_t             push_data_i,
  input  logic                pop_i,
  output wb_req_t             head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH-1:0]    ent_valid_o,
  output wb_req_t [DEPTH-1:0] ent_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  wb_req_t [DEPTH-1:0] mem_q;
  logic                do_push, do_pop;
  logic [PTR_W-1:0]    off;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign ent_o   = mem_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    off         = '0;
    ent_valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr_q;
      ent_valid_o[i] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipe results win the write port, slow results queue behind.
// Build option WB_BYPASS_EN lets a slow result skip the empty FIFO when the port is idle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_valid,
  input  logic [ADDR_W-1:0]    p_addr,
  input  logic [DATA_W-1:0]    p_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [ADDR_W-1:0]    s_addr,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [DATA_W-1:0]    wdata,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 stall_req
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  // Handshake: the slow unit's result transfers on any clock edge where
  // s_valid && s_ready; s_ready depends only on the registered FIFO count.

  logic                     pipe_wr, s_acc, s_nz, bypass;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_req_t                  s_req, head;
  wb_req_t [FIFO_DEPTH-1:0] ent;
  logic [FIFO_DEPTH-1:0]    ent_valid;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;

  assign pipe_wr    = p_valid && (p_addr != '0);
  assign s_ready    = !fifo_full;
  assign s_acc      = s_valid && s_ready;
  assign s_nz       = (s_addr != '0);
  assign s_req.addr = s_addr;
  assign s_req.data = s_data;

`ifdef WB_BYPASS_EN
  assign bypass = s_acc && s_nz && fifo_empty && !pipe_wr;
`else
  assign bypass = 1'b0;
`endif

  // Writes to r0 are dropped here, so they never occupy a slot.
  assign fifo_push = s_acc && s_nz && !bypass;
  assign fifo_pop  = !pipe_wr && !fifo_empty;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(s_req),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .ent_valid_o(ent_valid),
    .ent_o      (ent)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_wr) begin
      we_d    = 1'b1;
      waddr_d = p_addr;
      wdata_d = p_data;
    end else if (!fifo_empty) begin
      we_d    = 1'b1;
      waddr_d = head.addr;
      wdata_d = head.data;
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = s_addr;
      wdata_d = s_data;
    end
  end

  // Counts cycles the head waited because the pipe owned the port.
  always_comb begin
    starve_d = '0;
    if (!fifo_empty && !fifo_pop) begin
      starve_d = (starve_q == SC_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
    stall_d = (starve_d == SC_W'(STARVE_MAX));
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pend_mask = pend_mask | onehot_addr(ent[i].addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter; expectations adapt to WB_BYPASS_EN.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sr;
    logic [31:0] pm;
    logic        st;
  } vec_t;

  vec_t tbl[$];

  wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic pv, logic [4:0] pa, logic [31:0] pd,
                              logic sv, logic [4:0] sa, logic [31:0] sd,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                              logic esr, logic [31:0] epm, logic est);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pd = pd;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.we = ewe; v.wa = ewa; v.wd = ewd;
    v.sr = esr; v.pm = epm; v.st = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ewe, input logic [4:0] ewa,
                               input logic [31:0] ewd, input logic esr,
                               input logic [31:0] epm, input logic est);
    chk({tag, ".we"},        {63'd0, we},        {63'd0, ewe});
    chk({tag, ".waddr"},     {59'd0, waddr},     {59'd0, ewa});
    chk({tag, ".wdata"},     {32'd0, wdata},     {32'd0, ewd});
    chk({tag, ".s_ready"},   {63'd0, s_ready},   {63'd0, esr});
    chk({tag, ".pend_mask"}, {32'd0, pend_mask}, {32'd0, epm});
    chk({tag, ".stall_req"}, {63'd0, stall_req}, {63'd0, est});
  endtask

  // driver: apply one vector, clock it, compare the registered result
  task automatic apply_vec(input vec_t v, input string tag);
    p_valid = v.pv; p_addr = v.pa; p_data = v.pd;
    s_valid = v.sv; s_addr = v.sa; s_data = v.sd;
    if (v.pv && v.pa != 5'd0) begin
      chk({tag, ".waw_hazard"}, {63'd0, pend_mask[v.pa]}, 64'd0);
      chk({tag, ".pipe_during_stall"}, {63'd0, stall_req}, 64'd0);
    end
    @(posedge clk);
    #1;
    check_outputs(tag, v.we, v.wa, v.wd, v.sr, v.pm, v.st);
  endtask

  task automatic idle_inputs();
    p_valid = 1'b0; p_addr = '0; p_data = '0;
    s_valid = 1'b0; s_addr = '0; s_data = '0;
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    rst = 1'b0;

    //        pv pa  pd            sv sa  sd         we wa  wd            sr pm          st
    tbl.push_back(mk(1, 3,  32'hDEADBEEF, 0, 0,  0,         1, 3,  32'hDEADBEEF, 1, 32'h0,       0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         0, 3,  32'hDEADBEEF, 1, 32'h0,       0));
    // pipe busy, two slow pushes fill the FIFO, drained in order once the pipe idles
    tbl.push_back(mk(1, 1,  32'h101,      1, 7,  32'h11,    1, 1,  32'h101,      1, 32'h80,      0));
    tbl.push_back(mk(1, 2,  32'h102,      1, 8,  32'h22,    1, 2,  32'h102,      0, 32'h180,     0));
    tbl.push_back(mk(1, 3,  32'h103,      0, 0,  0,         1, 3,  32'h103,      0, 32'h180,     0));
    tbl.push_back(mk(1, 4,  32'h104,      0, 0,  0,         1, 4,  32'h104,      0, 32'h180,     0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         1, 7,  32'h11,       1, 32'h100,     0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         1, 8,  32'h22,       1, 32'h0,       0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         0, 8,  32'h22,       1, 32'h0,       0));
    // starvation: r9 blocked four cycles raises stall_req, the pop clears it
    tbl.push_back(mk(1, 10, 32'hA0,       1, 9,  32'h99,    1, 10, 32'hA0,       1, 32'h200,     0));
    tbl.push_back(mk(1, 11, 32'hA1,       0, 0,  0,         1, 11, 32'hA1,       1, 32'h200,     0));
    tbl.push_back(mk(1, 12, 32'hA2,       0, 0,  0,         1, 12, 32'hA2,       1, 32'h200,     0));
    tbl.push_back(mk(1, 13, 32'hA3,       0, 0,  0,         1, 13, 32'hA3,       1, 32'h200,     0));
    tbl.push_back(mk(1, 14, 32'hA4,       0, 0,  0,         1, 14, 32'hA4,       1, 32'h200,     1));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         1, 9,  32'h99,       1, 32'h0,       0));
    // r0 from both sources is dropped
    tbl.push_back(mk(1, 0,  32'hBAD,      1, 0,  32'hBAD2,  0, 9,  32'h99,       1, 32'h0,       0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         0, 9,  32'h99,       1, 32'h0,       0));
    // pipe write to r0 counts as idle, so the FIFO pops
    tbl.push_back(mk(1, 20, 32'h14,       1, 21, 32'h15,    1, 20, 32'h14,       1, 32'h200000,  0));
    tbl.push_back(mk(1, 0,  32'hBAD,      0, 0,  0,         1, 21, 32'h15,       1, 32'h0,       0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         0, 21, 32'h15,       1, 32'h0,       0));
    // push and pop in the same cycle keep one entry
    tbl.push_back(mk(1, 1,  32'h1,        1, 2,  32'h22,    1, 1,  32'h1,        1, 32'h4,       0));
    tbl.push_back(mk(0, 0,  0,            1, 3,  32'h33,    1, 2,  32'h22,       1, 32'h8,       0));
    tbl.push_back(mk(0, 0,  0,            0, 0,  0,         1, 3,  32'h33,       1, 32'h0,       0));

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec(tbl[i], $sformatf("v%0d", i));
    end

    // fill the FIFO, then reset asynchronously between edges
    apply_vec(mk(1, 1, 32'h1, 1, 12, 32'hC, 1, 1, 32'h1, 1, 32'h1000, 0), "fill0");
    apply_vec(mk(1, 2, 32'h2, 1, 13, 32'hD, 1, 2, 32'h2, 0, 32'h3000, 0), "fill1");
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0), "post_rst0");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0), "post_rst1");

    // slow r5 with an idle pipe and empty FIFO
`ifdef WB_BYPASS_EN
    apply_vec(mk(0, 0, 0, 1, 5, 32'h55, 1, 5, 32'h55, 1, 32'h0, 0), "byp0");
    apply_vec(mk(0, 0, 0, 0, 0, 0,      0, 5, 32'h55, 1, 32'h0, 0), "byp1");
`else
    apply_vec(mk(0, 0, 0, 1, 5, 32'h55, 0, 0, 32'h0,  1, 32'h20, 0), "slow0");
    apply_vec(mk(0, 0, 0, 0, 0, 0,      1, 5, 32'h55, 1, 32'h0,  0), "slow1");
`endif
    v = mk(0, 0, 0, 0, 0, 0, 0, 5, 32'h55, 1, 32'h0, 0);
    apply_vec(v, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
